// File: rtl/spi_master_xfer.sv
// spi_master_xfer: single-frame SPI master with configurable width, divider,
// guard time and CPOL/CPHA. Host side is ready/valid; ss is active high.
module spi_master_xfer #(
  parameter int FRAME_BITS = 16,
  parameter int DIV_W      = 8,
  parameter int GUARD      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start_valid,
  output logic                  start_ready,
  input  logic [FRAME_BITS-1:0] tx_data,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DIV_W-1:0]      clkdiv,
  input  logic                  abort,
  output logic                  sclk,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  rx_valid,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  busy
);

  localparam int EW = $clog2(2 * FRAME_BITS);
  localparam int GW = $clog2(GUARD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TRAIL,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    sclk_q, sclk_d;
  logic                    cpol_q, cpol_d;
  logic                    cpha_q, cpha_d;
  logic [DIV_W-1:0]        div_lim_q, div_lim_d;
  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [EW-1:0]           edge_q, edge_d;
  logic [GW-1:0]           guard_q, guard_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [FRAME_BITS-1:0]   rx_sh_q, rx_sh_d;
  logic [FRAME_BITS-1:0]   rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;

  logic ss_int;
  logic div_tc;
  logic lead_edge;
  logic last_edge;
  logic guard_tc;

  assign ss_int    = (state_q == S_LEAD) || (state_q == S_SHIFT) ||
                     (state_q == S_TRAIL);
  assign div_tc    = (div_cnt_q == div_lim_q);
  // Even toggles move sclk away from cpol.
  assign lead_edge = ~edge_q[0];
  assign last_edge = (edge_q == EW'(2 * FRAME_BITS - 1));
  assign guard_tc  = (guard_q == GW'(GUARD - 1));

  always_comb begin
    state_d    = state_q;
    sclk_d     = sclk_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_lim_d  = div_lim_q;
    div_cnt_d  = div_cnt_q;
    edge_d     = edge_q;
    guard_d    = guard_q;
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        sclk_d = cpol;
        if (start_valid) begin
          tx_d      = tx_data;
          cpol_d    = cpol;
          cpha_d    = cpha;
          div_lim_d = clkdiv;
          guard_d   = '0;
          state_d   = S_LEAD;
        end
      end
      S_LEAD: begin
        if (guard_tc) begin
          div_cnt_d = '0;
          edge_d    = '0;
          state_d   = S_SHIFT;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_tc) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          edge_d    = edge_q + 1'b1;
          if (lead_edge ^ cpha_q) begin
            rx_sh_d = {rx_sh_q[FRAME_BITS-2:0], miso};
          end else if (cpha_q ? (edge_q != '0) : !last_edge) begin
            // MSB is already on mosi, so the first CPHA=1 launch is a no-op.
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          end
          if (last_edge) begin
            guard_d = '0;
            state_d = S_TRAIL;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      S_TRAIL: begin
        if (guard_tc) begin
          state_d = S_DONE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      S_DONE: begin
        rx_data_d  = rx_sh_q;
        rx_valid_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && ss_int) begin
      state_d = S_IDLE;
      sclk_d  = cpol_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      sclk_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      div_lim_q  <= '0;
      div_cnt_q  <= '0;
      edge_q     <= '0;
      guard_q    <= '0;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      div_lim_q  <= div_lim_d;
      div_cnt_q  <= div_cnt_d;
      edge_q     <= edge_d;
      guard_q    <= guard_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ss          = ss_int;
  assign sclk        = sclk_q;
  assign mosi        = ss_int & tx_q[FRAME_BITS-1];
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;

endmodule
